pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//   Next-PC controller for the fetch stage. Each cycle it selects the PC-register load value
//   (sequential, branch, jump or exception vector) and drives the PC register hold.
//   It also generates IF/ID flush strobes and sequences boot, hazard stalls and debug halt.
//   It sits between hazard/branch resolution logic and the PC register; pc_cur is fed back from it.
// PARAMETERS
//   PC_W        8      PC width in bits; word-indexed instruction address
//   BOOT_CYCLES 4      cycles PC is held at 0 after reset release (imem warm-up); >=1
//   EXC_VEC     8'h20  exception handler address (PC_W bits)
//   STALL_MAX   15     consecutive stall cycles tolerated before timeout; >=1
// PORTS
//   clock          in   1        rising-edge clock
//   reset_n        in   1        asynchronous, active-low reset
//   pc_cur         in   PC_W     current PC register value
//   stall_req      in   1        load-use hazard; freeze PC this cycle
//   branch_taken   in   1        EX-stage branch resolved taken
//   branch_target  in   PC_W     branch destination
//   jump_valid     in   1        ID-stage jump decoded
//   jump_target    in   PC_W     jump destination
//   exc_req        in   1        exception request (single-cycle pulse)
//   halt_req       in   1        debug halt request
//   resume         in   1        leave HALT (single-cycle pulse)
//   next_pc        out  32       PC register load value; zero-extended from PC_W
//   pc_hold        out  1        1 = PC register keeps its value
//   flush_if       out  1        squash the instruction in IF/ID
//   flush_id       out  1        squash the instruction in ID/EX
//   seq_state      out  3        FSM state: BOOT=0 RUN=1 STALL=2 HALT=3
//   stall_timeout  out  1        sticky error; stall exceeded STALL_MAX
// BEHAVIOUR
//   Reset (async, reset_n=0): state=BOOT, boot_cnt=0, stall_cnt=0, stall_timeout=0.
//     Outputs: pc_hold=1, next_pc=0, flush_if=0, flush_id=0, seq_state=0.
//   Registered state only; next_pc/pc_hold/flush_* are combinational from state + inputs.
//     PC register captures next_pc on the same edge, so a redirect costs zero extra cycles.
//   BOOT: pc_hold=1, next_pc=0, all requests ignored.
//     boot_cnt increments each cycle; at boot_cnt==BOOT_CYCLES-1 -> RUN.
//   RUN/STALL priority, highest first. Evaluate each cycle; lower items ignored when a higher one fires.
//     1 exc_req: next_pc=EXC_VEC, pc_hold=0, flush_if=flush_id=1; -> RUN, stall_cnt=0.
//     2 branch_taken: next_pc=branch_target, pc_hold=0, flush_if=flush_id=1; -> RUN, stall_cnt=0.
//       The branch is older than the jump and wins over a simultaneous jump_valid.
//     3 jump_valid: next_pc=jump_target, pc_hold=0, flush_if=1, flush_id=0; -> RUN, stall_cnt=0.
//     4 halt_req: pc_hold=1, next_pc=pc_cur; -> HALT. Takes effect only when none of 1-3 fire.
//     5 stall_req: pc_hold=1, next_pc=pc_cur, flush_id=1 (bubble into EX); -> STALL; stall_cnt+1.
//       If stall_cnt==STALL_MAX-1 on entry to item 5: set stall_timeout=1 and -> HALT.
//     6 otherwise: next_pc=(pc_cur+1) mod 2^PC_W (all-ones wraps to 0), pc_hold=0; -> RUN, stall_cnt=0.
//   HALT: pc_hold=1, next_pc=pc_cur, flush_*=0.
//     exc_req, branch_taken, jump_valid and stall_req are ignored; stall_cnt is cleared.
//     resume=1 -> RUN. halt_req held across resume re-enters HALT on the next cycle.
//   stall_timeout: cleared only by reset; resume does not clear it.
//   Reset asserted mid-operation: immediate return to reset values; any pending redirect is lost.
//   Targets are taken verbatim; no alignment or range checks.
// TESTING
//   Reset release, BOOT_CYCLES=4: pc_hold=1, next_pc=0 for 4 cycles.
//     Then RUN with pc_cur=0 -> next_pc=1, pc_hold=0.
//   RUN, pc_cur=8'hFF, no requests -> next_pc=0 (wrap), seq_state=1.
//   pc_cur=5, branch_taken=1 (target 8'h40) and jump_valid=1 (target 8'h10) together
//     -> next_pc=8'h40, flush_if=1, flush_id=1.
//   pc_cur=5, stall_req 3 cycles -> pc_hold=1, next_pc=5, flush_id=1, seq_state=2 for 3 cycles.
//     Then next_pc=6, seq_state=1.
//   stall_req held 15 cycles (STALL_MAX=15) -> stall_timeout=1, seq_state=3.
//     exc_req pulse ignored; resume -> RUN; stall_timeout stays 1.
//   exc_req during STALL with pc_cur=9 -> next_pc=8'h20, flush_if=flush_id=1, seq_state=1 next cycle.
//     reset_n=0 mid-stream -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: next-PC controller for the fetch stage.
//   Selects the PC register load value (sequential, branch, jump, exception
//   vector), drives the PC hold, raises IF/ID and ID/EX flush strobes and
//   sequences boot warm-up, load-use stalls (with a timeout) and debug halt.
// Ports:
//   clock, reset_n     rising-edge clock, async active-low reset
//   pc_cur             current PC register value (fed back)
//   stall_req          load-use hazard, freeze PC
//   branch_taken/_target   EX-stage taken branch
//   jump_valid/jump_target ID-stage jump
//   exc_req            exception pulse -> EXC_VEC
//   halt_req, resume   debug halt entry / exit
//   next_pc            PC load value, zero-extended to 32 bits
//   pc_hold            1 = PC register keeps its value
//   flush_if, flush_id squash IF/ID, ID/EX contents
//   seq_state          BOOT=0 RUN=1 STALL=2 HALT=3
//   stall_timeout      sticky, set when a stall runs STALL_MAX cycles
module pc_sequencer #(
  parameter int              PC_W        = 8,
  parameter int              BOOT_CYCLES = 4,
  parameter logic [PC_W-1:0] EXC_VEC     = 8'h20,
  parameter int              STALL_MAX   = 15
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic [PC_W-1:0] pc_cur,
  input  logic            stall_req,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_target,
  input  logic            jump_valid,
  input  logic [PC_W-1:0] jump_target,
  input  logic            exc_req,
  input  logic            halt_req,
  input  logic            resume,
  output logic [31:0]     next_pc,
  output logic            pc_hold,
  output logic            flush_if,
  output logic            flush_id,
  output logic [2:0]      seq_state,
  output logic            stall_timeout
);

  localparam int BW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam int SW = (STALL_MAX > 1) ? $clog2(STALL_MAX) : 1;
  localparam logic [BW-1:0] BOOT_LAST  = BW'(BOOT_CYCLES - 1);
  localparam logic [SW-1:0] STALL_LAST = SW'(STALL_MAX - 1);

  typedef enum logic [2:0] {
    S_BOOT  = 3'd0,
    S_RUN   = 3'd1,
    S_STALL = 3'd2,
    S_HALT  = 3'd3
  } state_t;

  state_t          state, state_nxt;
  logic [BW-1:0]   boot_cnt, boot_nxt;
  logic [SW-1:0]   stall_cnt, stall_nxt;
  logic            timeout_nxt;
  logic [PC_W-1:0] npc;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_BOOT;
      boot_cnt      <= '0;
      stall_cnt     <= '0;
      stall_timeout <= 1'b0;
    end else begin
      state         <= state_nxt;
      boot_cnt      <= boot_nxt;
      stall_cnt     <= stall_nxt;
      stall_timeout <= timeout_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    boot_nxt    = boot_cnt;
    stall_nxt   = stall_cnt;
    timeout_nxt = stall_timeout;
    npc         = pc_cur;
    pc_hold     = 1'b1;
    flush_if    = 1'b0;
    flush_id    = 1'b0;
    unique case (state)
      S_BOOT: begin
        npc      = '0;
        boot_nxt = boot_cnt + 1'b1;
        if (boot_cnt == BOOT_LAST) state_nxt = S_RUN;
      end
      S_RUN, S_STALL: begin
        // Redirects and sequential fetch all leave the stall run, so the
        // counter defaults to cleared and only the stall path advances it.
        stall_nxt = '0;
        state_nxt = S_RUN;
        if (exc_req) begin
          npc      = EXC_VEC;
          pc_hold  = 1'b0;
          flush_if = 1'b1;
          flush_id = 1'b1;
        end else if (branch_taken) begin
          // Branch in EX is older than a jump in ID, so it wins.
          npc      = branch_target;
          pc_hold  = 1'b0;
          flush_if = 1'b1;
          flush_id = 1'b1;
        end else if (jump_valid) begin
          npc      = jump_target;
          pc_hold  = 1'b0;
          flush_if = 1'b1;
        end else if (halt_req) begin
          state_nxt = S_HALT;
        end else if (stall_req) begin
          flush_id = 1'b1;  // bubble into EX while IF/ID is frozen
          if (stall_cnt == STALL_LAST) begin
            timeout_nxt = 1'b1;
            state_nxt   = S_HALT;
          end else begin
            stall_nxt = stall_cnt + 1'b1;
            state_nxt = S_STALL;
          end
        end else begin
          npc     = pc_cur + PC_W'(1);  // wraps at all-ones
          pc_hold = 1'b0;
        end
      end
      S_HALT: begin
        stall_nxt = '0;
        if (resume) state_nxt = S_RUN;
      end
      default: begin
        state_nxt = S_BOOT;
      end
    endcase
  end

  assign next_pc   = 32'(npc);
  assign seq_state = state;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with default parameters
// (PC_W=8, BOOT_CYCLES=4, EXC_VEC=8'h20, STALL_MAX=15).
module tb_pc_sequencer;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [7:0]  pc_cur;
  logic        stall_req, branch_taken, jump_valid, exc_req, halt_req, resume;
  logic [7:0]  branch_target, jump_target;
  logic [31:0] next_pc;
  logic        pc_hold, flush_if, flush_id, stall_timeout;
  logic [2:0]  seq_state;

  int total  = 0;
  int passed = 0;

  pc_sequencer dut (
    .clock(clock), .reset_n(reset_n), .pc_cur(pc_cur),
    .stall_req(stall_req), .branch_taken(branch_taken),
    .branch_target(branch_target), .jump_valid(jump_valid),
    .jump_target(jump_target), .exc_req(exc_req), .halt_req(halt_req),
    .resume(resume), .next_pc(next_pc), .pc_hold(pc_hold),
    .flush_if(flush_if), .flush_id(flush_id), .seq_state(seq_state),
    .stall_timeout(stall_timeout)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Combinational outputs for the current cycle.
  task automatic chk_out(input string tag, input logic [31:0] npc, input logic hold,
                         input logic fi, input logic fd);
    chk({tag, ".next_pc"},  next_pc,  npc);
    chk({tag, ".pc_hold"},  32'(pc_hold),  32'(hold));
    chk({tag, ".flush_if"}, 32'(flush_if), 32'(fi));
    chk({tag, ".flush_id"}, 32'(flush_id), 32'(fd));
  endtask

  // Advance one clock; inputs change and checks happen 1-2 ns after the edge.
  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic idle;
    stall_req = 0; branch_taken = 0; jump_valid = 0;
    exc_req = 0; halt_req = 0; resume = 0;
  endtask

  initial begin
    reset_n = 0; pc_cur = 8'h00; branch_target = 8'h00; jump_target = 8'h00;
    idle();
    #2;
    chk_out("reset", 32'h0, 1'b1, 1'b0, 1'b0);
    chk("reset.seq_state", 32'(seq_state), 32'd0);
    chk("reset.timeout", 32'(stall_timeout), 32'd0);

    // Boot: 4 cycles holding PC at 0, requests ignored.
    tick();
    reset_n = 1;
    exc_req = 1; branch_taken = 1; branch_target = 8'h40; pc_cur = 8'h33;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk_out($sformatf("boot%0d", i), 32'h0, 1'b1, 1'b0, 1'b0);
      chk($sformatf("boot%0d.state", i), 32'(seq_state), 32'd0);
      tick();
    end
    idle(); pc_cur = 8'h00;
    #1;
    chk("run0.state", 32'(seq_state), 32'd1);
    chk_out("run0", 32'h1, 1'b0, 1'b0, 1'b0);

    // Wrap.
    pc_cur = 8'hFF;
    #1;
    chk_out("wrap", 32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("wrap.state", 32'(seq_state), 32'd1);

    // Branch beats simultaneous jump.
    pc_cur = 8'h05; branch_taken = 1; branch_target = 8'h40;
    jump_valid = 1; jump_target = 8'h10;
    #1;
    chk_out("br_vs_jmp", 32'h40, 1'b0, 1'b1, 1'b1);
    tick();
    branch_taken = 0;
    #1;
    chk_out("jump", 32'h10, 1'b0, 1'b1, 1'b0);
    tick();
    idle();

    // Three-cycle stall at pc 5.
    stall_req = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk_out($sformatf("stall%0d", i), 32'h5, 1'b1, 1'b0, 1'b1);
      tick();
      chk($sformatf("stall%0d.state", i), 32'(seq_state), 32'd2);
    end
    stall_req = 0;
    #1;
    chk_out("unstall", 32'h6, 1'b0, 1'b0, 1'b0);
    tick();
    chk("unstall.state", 32'(seq_state), 32'd1);

    // Stall timeout after 15 consecutive cycles.
    pc_cur = 8'h07; stall_req = 1;
    for (int i = 0; i < 14; i++) tick();
    chk("to14.timeout", 32'(stall_timeout), 32'd0);
    chk("to14.state", 32'(seq_state), 32'd2);
    #1;
    chk_out("to15", 32'h7, 1'b1, 1'b0, 1'b1);
    tick();
    chk("to15.timeout", 32'(stall_timeout), 32'd1);
    chk("to15.state", 32'(seq_state), 32'd3);

    // Exception ignored in HALT.
    stall_req = 0; exc_req = 1;
    #1;
    chk_out("halt_exc", 32'h7, 1'b1, 1'b0, 1'b0);
    tick();
    exc_req = 0;
    chk("halt_exc.state", 32'(seq_state), 32'd3);
    resume = 1;
    tick();
    resume = 0;
    chk("resume.state", 32'(seq_state), 32'd1);
    chk("resume.timeout", 32'(stall_timeout), 32'd1);

    // Debug halt with halt_req held across resume.
    pc_cur = 8'h03; halt_req = 1;
    #1;
    chk_out("halt_in", 32'h3, 1'b1, 1'b0, 1'b0);
    tick();
    chk("halt_in.state", 32'(seq_state), 32'd3);
    resume = 1;
    tick();
    resume = 0;
    chk("reenter.run", 32'(seq_state), 32'd1);
    tick();
    chk("reenter.halt", 32'(seq_state), 32'd3);
    halt_req = 0; resume = 1;
    tick();
    resume = 0;
    chk("leave.state", 32'(seq_state), 32'd1);

    // Exception during STALL.
    pc_cur = 8'h09; stall_req = 1;
    tick();
    chk("exc_stall.pre", 32'(seq_state), 32'd2);
    exc_req = 1; branch_taken = 1; branch_target = 8'h44;
    #1;
    chk_out("exc_stall", 32'h20, 1'b0, 1'b1, 1'b1);
    tick();
    exc_req = 0; branch_taken = 0;
    chk("exc_stall.state", 32'(seq_state), 32'd1);

    // Mid-stream reset with a pending redirect.
    tick();
    chk("prerst.state", 32'(seq_state), 32'd2);
    branch_taken = 1;
    #2;
    reset_n = 0;
    #1;
    chk_out("midrst", 32'h0, 1'b1, 1'b0, 1'b0);
    chk("midrst.state", 32'(seq_state), 32'd0);
    chk("midrst.timeout", 32'(stall_timeout), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
